// File: rtl/ipsxe_fft_result_checker.sv
// FFT output checker: compares each AXI4-Stream beat against an external golden ROM over
// FRAME_NUM frames and reports sticky error/finished flags plus a saturating error count.
module ipsxe_fft_result_checker #(
  parameter int unsigned FFT_LEN   = 1024,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned FRAME_NUM = 4,
  parameter int unsigned TOL       = 4,
  parameter int unsigned TIMEOUT   = 65535
) (
  input  logic                                          i_clk,
  input  logic                                          i_rstn,
  input  logic                                          i_start_test,
  input  logic                                          i_axi4s_data_tvalid,
  input  logic [2*DATA_W-1:0]                           i_axi4s_data_tdata,
  input  logic                                          i_axi4s_data_tlast,
  output logic                                          o_axi4s_data_tready,
  output logic [$clog2(FFT_LEN)+$clog2(FRAME_NUM)-1:0]  o_exp_addr,
  input  logic [2*DATA_W-1:0]                           i_exp_data,
  output logic                                          o_err,
  output logic                                          o_chk_finished,
  output logic [15:0]                                   o_err_cnt
);

  localparam int unsigned SW = $clog2(FFT_LEN);
  localparam int unsigned FW = $clog2(FRAME_NUM);
  localparam int unsigned IW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] CHECK = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]          state;
  logic                start_q;
  logic [SW-1:0]       sample_idx;
  logic [FW-1:0]       frame_idx;
  logic [IW-1:0]       idle_cnt;
  logic                cmp_vld;
  logic [2*DATA_W-1:0] data_q;
  logic                last_q;
  logic                exp_last_q;
  logic [1:0]          fin_pipe;

  logic                accept;
  logic                start_edge;
  logic                last_sample;
  logic                final_beat;
  logic                timeout;
  logic [DATA_W:0]     diff_re;
  logic [DATA_W:0]     diff_im;
  logic                mismatch;

  // |a-b| computed in DATA_W+1 bits so the full two's complement range never overflows
  function automatic logic [DATA_W:0] abs_diff(input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
    logic signed [DATA_W:0] d;
    d = $signed({a[DATA_W-1], a}) - $signed({b[DATA_W-1], b});
    return d[DATA_W] ? $unsigned(-d) : $unsigned(d);
  endfunction

  assign o_axi4s_data_tready = (state == CHECK);
  assign o_exp_addr          = {frame_idx, sample_idx};
  assign accept              = i_axi4s_data_tvalid & o_axi4s_data_tready;
  assign start_edge          = i_start_test & ~start_q;
  assign last_sample         = (sample_idx == SW'(FFT_LEN - 1));
  assign final_beat          = accept & last_sample & (frame_idx == FW'(FRAME_NUM - 1));
  assign timeout             = (state == CHECK) & ~accept & (idle_cnt == IW'(TIMEOUT));

  assign diff_re  = abs_diff(data_q[DATA_W-1:0], i_exp_data[DATA_W-1:0]);
  assign diff_im  = abs_diff(data_q[2*DATA_W-1:DATA_W], i_exp_data[2*DATA_W-1:DATA_W]);
  assign mismatch = cmp_vld & ((diff_re > (DATA_W+1)'(TOL)) | (diff_im > (DATA_W+1)'(TOL)) |
                               (last_q != exp_last_q));

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state          <= IDLE;
      start_q        <= 1'b0;
      sample_idx     <= '0;
      frame_idx      <= '0;
      idle_cnt       <= '0;
      cmp_vld        <= 1'b0;
      data_q         <= '0;
      last_q         <= 1'b0;
      exp_last_q     <= 1'b0;
      fin_pipe       <= '0;
      o_err          <= 1'b0;
      o_chk_finished <= 1'b0;
      o_err_cnt      <= '0;
    end else begin
      start_q  <= i_start_test;
      cmp_vld  <= accept;
      fin_pipe <= {fin_pipe[0], final_beat};

      unique case (state)
        IDLE:    if (start_edge) state <= CHECK;
        CHECK:   if (final_beat || timeout) state <= DONE;
        DONE:    ;
        default: state <= IDLE;
      endcase

      // Framing comes from the counters alone; the stream's tlast is only checked
      if (accept) begin
        data_q     <= i_axi4s_data_tdata;
        last_q     <= i_axi4s_data_tlast;
        exp_last_q <= last_sample;
        idle_cnt   <= '0;
        if (last_sample) begin
          sample_idx <= '0;
          frame_idx  <= frame_idx + 1'b1;
        end else begin
          sample_idx <= sample_idx + 1'b1;
        end
      end else if ((state == CHECK) && !timeout) begin
        idle_cnt <= idle_cnt + 1'b1;
      end

      if (mismatch) begin
        o_err <= 1'b1;
        if (o_err_cnt != 16'hFFFF) o_err_cnt <= o_err_cnt + 16'd1;
      end
      if (timeout) o_err <= 1'b1;

      // Finish one edge after the final compare so every error is already visible
      if (timeout || fin_pipe[1]) o_chk_finished <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ipsxe_fft_result_checker.sv
// Bench for ipsxe_fft_result_checker: golden ROM model, address scoreboard and directed
// fault scenarios (tolerance edge, tlast fault, gapped valid, timeout, mid-frame reset).
module tb_ipsxe_fft_result_checker;

  localparam int unsigned FFT_LEN   = 1024;
  localparam int unsigned DATA_W    = 16;
  localparam int unsigned FRAME_NUM = 4;
  localparam int unsigned TOL       = 4;
  localparam int unsigned TIMEOUT   = 200;
  localparam int          TOTAL     = FFT_LEN * FRAME_NUM;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start;
  logic        tvalid;
  logic [31:0] tdata;
  logic        tlast;
  logic        tready;
  logic [11:0] exp_addr;
  logic [31:0] rom_q;
  logic        err;
  logic        finished;
  logic [15:0] err_cnt;

  int vectors     = 0;
  int miscompares = 0;
  logic [11:0] sb_q[$];

  always #5 clk = ~clk;

  ipsxe_fft_result_checker #(
    .FFT_LEN   (FFT_LEN),
    .DATA_W    (DATA_W),
    .FRAME_NUM (FRAME_NUM),
    .TOL       (TOL),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .i_clk               (clk),
    .i_rstn              (rstn),
    .i_start_test        (start),
    .i_axi4s_data_tvalid (tvalid),
    .i_axi4s_data_tdata  (tdata),
    .i_axi4s_data_tlast  (tlast),
    .o_axi4s_data_tready (tready),
    .o_exp_addr          (exp_addr),
    .i_exp_data          (rom_q),
    .o_err               (err),
    .o_chk_finished      (finished),
    .o_err_cnt           (err_cnt)
  );

  function automatic logic [31:0] gold(input logic [11:0] a);
    logic [15:0] re, im;
    re = 16'(a) * 16'd37 + 16'd5;
    im = (16'(a) * 16'd11) ^ 16'h5a5a;
    return {im, re};
  endfunction

  // Synchronous ROM: data valid one cycle after the address
  always @(posedge clk) rom_q <= gold(exp_addr);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (rstn && tvalid && tready) begin
      if (sb_q.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
      else chk("exp_addr", 32'(exp_addr), 32'(sb_q.pop_front()));
    end
  end

  task automatic reset_dut();
    rstn   = 1'b0;
    start  = 1'b0;
    tvalid = 1'b0;
    tdata  = '0;
    tlast  = 1'b0;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    sb_q.delete();
  endtask

  task automatic pulse_start();
    start = 1'b0;
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // mode: 0 golden, 1 tolerance edge, 2 tlast fault, 4 golden with a stray start pulse
  task automatic run_stream(input int mode, input int vpct, input int limit);
    int b;
    int cyc;
    int watch;
    logic [31:0] d;
    logic [11:0] a;
    b = 0;
    cyc = 0;
    watch = 0;
    while (b < limit && cyc < 30000) begin
      @(posedge clk);
      #1 cyc++;
      if (watch > 0) begin
        watch++;
        if (watch == 2) chk("tol_err_early", 32'(err), 32'd0);
        if (watch == 3) chk("tol_err_rise", 32'(err), 32'd1);
      end
      if (mode == 4 && b == 2000) start = 1'b0;
      if (mode == 4 && b == 2010) start = 1'b1;
      a = b[11:0];
      d = gold(a);
      if (mode == 1 && b == 5) d[15:0] = d[15:0] + 16'd4;
      if (mode == 1 && b == 6) d[31:16] = d[31:16] - 16'd5;
      tvalid = ($urandom_range(99) < vpct);
      tdata  = d;
      tlast  = ((b % FFT_LEN) == FFT_LEN - 1);
      if (mode == 2 && b == FFT_LEN + 511) tlast = 1'b1;
      if (mode == 2 && b == 2 * FFT_LEN - 1) tlast = 1'b0;
      if (tvalid && tready) begin
        sb_q.push_back(a);
        if (mode == 1 && b == 6) watch = 1;
        b++;
      end
    end
    @(posedge clk);
    #1 tvalid = 1'b0;
    tlast = 1'b0;
    chk("beats_sent", 32'(b), 32'(limit));
  endtask

  task automatic check_final(input string tag, input logic [15:0] want_cnt);
    chk({tag, "_tready_drop"}, 32'(tready), 32'd0);
    repeat (4) @(posedge clk);
    #1;
    chk({tag, "_finished"}, 32'(finished), 32'd1);
    chk({tag, "_err"}, 32'(err), 32'(want_cnt != 0));
    chk({tag, "_err_cnt"}, 32'(err_cnt), 32'(want_cnt));
    chk({tag, "_sb_empty"}, 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    reset_dut();
    chk("rst_tready", 32'(tready), 32'd0);
    chk("rst_addr", 32'(exp_addr), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_finished", 32'(finished), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);

    // Beats offered in IDLE are ignored
    tvalid = 1'b1;
    repeat (5) @(posedge clk);
    #1 tvalid = 1'b0;
    chk("idle_addr", 32'(exp_addr), 32'd0);

    pulse_start();
    chk("check_tready", 32'(tready), 32'd1);
    run_stream(0, 100, TOTAL);
    check_final("golden", 16'd0);

    reset_dut();
    pulse_start();
    run_stream(1, 100, TOTAL);
    check_final("tol", 16'd1);

    reset_dut();
    pulse_start();
    run_stream(2, 100, TOTAL);
    check_final("tlast", 16'd2);

    reset_dut();
    pulse_start();
    run_stream(0, 50, TOTAL);
    check_final("gapped", 16'd0);

    // Timeout: last accept on the edge just before this point
    reset_dut();
    pulse_start();
    run_stream(0, 100, 100);
    for (int k = 1; k <= int'(TIMEOUT) + 1; k++) begin
      @(posedge clk);
      #1;
      if (k == int'(TIMEOUT)) begin
        chk("to_fin_early", 32'(finished), 32'd0);
        chk("to_err_early", 32'(err), 32'd0);
      end
    end
    chk("to_finished", 32'(finished), 32'd1);
    chk("to_err", 32'(err), 32'd1);
    chk("to_tready", 32'(tready), 32'd0);
    chk("to_err_cnt", 32'(err_cnt), 32'd0);

    // Reset mid-frame, then a clean run with a stray start pulse during CHECK
    reset_dut();
    pulse_start();
    run_stream(0, 100, 300);
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("mid_rst_tready", 32'(tready), 32'd0);
    chk("mid_rst_addr", 32'(exp_addr), 32'd0);
    chk("mid_rst_err_cnt", 32'(err_cnt), 32'd0);
    rstn = 1'b1;
    sb_q.delete();
    pulse_start();
    run_stream(4, 100, TOTAL);
    check_final("restart", 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
